// File: rtl/twosum_start_multi.sv
// Multi-lane minifloat TwoSum front end: per-lane (elem + sum) giving rounded sum
// and exact rounding error, with a credit-controlled first-word-fall-through output FIFO.

module twosum_step #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int STEP_LAT_I   = 1,
  localparam int BW = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [BW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  input  logic          err_en_i,
  output logic [BW-1:0] sum_o,
  output logic [BW-1:0] err_o
);
  localparam int E  = EXP_WIDTH_I;
  localparam int M  = MANT_WIDTH_I;
  // Signed fixed point with LSB = smallest subnormal; wide enough for any finite sum.
  localparam int FW = M + (1 << E) + 2;

  function automatic logic signed [FW-1:0] to_fixed(input logic [BW-1:0] f);
    logic [FW-1:0] mag;
    if (f[M +: E] == '0) mag = FW'(f[M-1:0]);
    else                 mag = FW'({1'b1, f[M-1:0]}) << (f[M +: E] - 1'b1);
    return f[BW-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Round-to-nearest-even conversion; saturates to infinity past the largest finite value.
  function automatic logic [BW-1:0] to_float(input logic signed [FW-1:0] v);
    logic [FW-1:0]  mag;
    logic [E+M+1:0] enc;
    logic           guard;
    logic           sticky;
    int             p;
    int             sh;
    mag    = v[FW-1] ? FW'(-v) : FW'(v);
    p      = 0;
    guard  = 1'b0;
    sticky = 1'b0;
    for (int i = 0; i < FW; i++) if (mag[i]) p = i;
    if (p <= M) begin
      enc = (E+M+2)'(mag);
    end else begin
      sh     = p - M;
      enc    = {(E+2)'(sh + 1), M'(mag >> sh)};
      guard  = mag[sh-1];
      sticky = |(mag & ((FW'(1) << (sh - 1)) - FW'(1)));
      if (guard && (sticky || enc[0])) enc = enc + 1'b1;
    end
    if (enc[E+M+1:M] >= (E+2)'((1 << E) - 1)) enc = {(E+2)'((1 << E) - 1), M'(0)};
    return {v[FW-1], enc[E+M-1:0]};
  endfunction

  logic                 a_inf, b_inf, a_nan, b_nan;
  logic signed [FW-1:0] exact;
  logic [BW-1:0]        sum_c, err_c;

  always_comb begin
    a_inf = (&a_i[M +: E]) && !(|a_i[M-1:0]);
    b_inf = (&b_i[M +: E]) && !(|b_i[M-1:0]);
    a_nan = (&a_i[M +: E]) &&  (|a_i[M-1:0]);
    b_nan = (&b_i[M +: E]) &&  (|b_i[M-1:0]);
    exact = to_fixed(a_i) + to_fixed(b_i);
    err_c = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_i[BW-1] != b_i[BW-1])))
      sum_c = {1'b0, {E{1'b1}}, {M{1'b1}}};
    else if (a_inf) sum_c = a_i;
    else if (b_inf) sum_c = b_i;
    else begin
      sum_c = to_float(exact);
      // Residual of a finite round-to-nearest sum is exactly representable.
      if (!(&sum_c[M +: E]) && err_en_i) err_c = to_float(exact - to_fixed(sum_c));
    end
  end

  generate
    if (STEP_LAT_I == 0) begin : g_comb
      assign sum_o = sum_c;
      assign err_o = err_c;
    end else begin : g_pipe
      logic [2*BW-1:0] pipe [STEP_LAT_I];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < STEP_LAT_I; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= {sum_c, err_c};
          for (int i = 1; i < STEP_LAT_I; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign sum_o = pipe[STEP_LAT_I-1][2*BW-1:BW];
      assign err_o = pipe[STEP_LAT_I-1][BW-1:0];
    end
  endgenerate
endmodule

module twosum_start_multi #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int NUM_PAIRS_I  = 2,
  parameter int STEP_LAT_I   = 1,
  parameter int FIFO_DEPTH_I = 4,
  localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [2*NUM_PAIRS_I*BIT_WIDTH_I-1:0] elem_i,
  input  logic                                 err_en_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [NUM_PAIRS_I*BIT_WIDTH_I-1:0]   sum_o,
  output logic [NUM_PAIRS_I*BIT_WIDTH_I-1:0]   error_o,
  output logic                                 busy_o
);
  localparam int BW = BIT_WIDTH_I;
  localparam int LW = NUM_PAIRS_I * BW;
  localparam int L  = STEP_LAT_I + 2;
  localparam int CW = $clog2(FIFO_DEPTH_I + 1);
  localparam int PW = (FIFO_DEPTH_I > 1) ? $clog2(FIFO_DEPTH_I) : 1;

  logic [2*LW-1:0] in_elem;
  logic            in_err_en;
  logic [L-1:0]    vld;
  logic [LW-1:0]   step_sum, step_err;
  logic [LW-1:0]   out_sum, out_err;
  logic [2*LW-1:0] mem [FIFO_DEPTH_I];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, inflight;
  logic            accept, pop, wr_en;

  assign accept = in_valid_i && in_ready_o;
  assign wr_en  = vld[L-1];
  assign pop    = out_valid_o && out_ready_i;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + CW'(vld[i]);
  end

  // Credit counts every beat already committed to a FIFO slot, so a write never hits a full FIFO.
  assign in_ready_o  = ((CW+1)'(inflight) + (CW+1)'(count) < (CW+1)'(FIFO_DEPTH_I)) && !flush_i;
  assign out_valid_o = (count != '0);
  assign busy_o      = (inflight != '0) || (count != '0);
  assign sum_o       = mem[rd_ptr][2*LW-1:LW];
  assign error_o     = mem[rd_ptr][LW-1:0];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_DEPTH_I - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_elem   <= '0;
      in_err_en <= 1'b0;
      vld       <= '0;
      out_sum   <= '0;
      out_err   <= '0;
    end else begin
      in_elem   <= accept ? elem_i : '0;
      in_err_en <= accept && err_en_i;
      vld       <= flush_i ? '0 : {vld[L-2:0], accept};
      out_sum   <= step_sum;
      out_err   <= step_err;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAIRS_I; gi++) begin : g_lane
      twosum_step #(
        .EXP_WIDTH_I (EXP_WIDTH_I),
        .MANT_WIDTH_I(MANT_WIDTH_I),
        .STEP_LAT_I  (STEP_LAT_I)
      ) u_step (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .a_i     (in_elem[2*gi*BW +: BW]),
        .b_i     (in_elem[(2*gi+1)*BW +: BW]),
        .err_en_i(in_err_en),
        .sum_o   (step_sum[gi*BW +: BW]),
        .err_o   (step_err[gi*BW +: BW])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH_I; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {out_sum, out_err};
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_twosum_start_multi.sv
// Directed bench for twosum_start_multi (E5M2, two lanes, step latency 1, FIFO depth 4).

module tb_twosum_start_multi;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] elem_i;
  logic        err_en_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] sum_o;
  logic [15:0] error_o;
  logic        busy_o;

  twosum_start_multi dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .elem_i     (elem_i),
    .err_en_i   (err_en_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .sum_o      (sum_o),
    .error_o    (error_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] elem;
    logic        en;
    logic [15:0] s;
    logic [15:0] e;
  } vec_t;

  vec_t        vecs [8];
  int          errors = 0;
  int          checks = 0;
  int          pop_cnt = 0;
  logic [31:0] cur_exp;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int idx);
    elem_i   = vecs[idx].elem;
    err_en_i = vecs[idx].en;
    cur_exp  = {vecs[idx].s, vecs[idx].e};
  endtask

  // Scoreboard: accepted beats queued in order, every pop compared against the head.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_order: unexpected beat sum=0x%0h err=0x%0h with nothing outstanding", sum_o, error_o);
        end else begin
          check("pop_order", {sum_o, error_o}, exp_q.pop_front());
        end
      end
      if (flush_i) exp_q.delete();
      else if (in_valid_i && in_ready_o) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, k, p0;
    logic rdy;
    vecs[0] = '{32'h3C3C3C2C, 1'b1, 16'h403C, 16'h002C};
    vecs[1] = '{32'h3C3C3C2C, 1'b0, 16'h403C, 16'h0000};
    vecs[2] = '{32'hC0403D3C, 1'b1, 16'h0040, 16'h0034};
    vecs[3] = '{32'h02013E3F, 1'b1, 16'h0342, 16'h0034};
    vecs[4] = '{32'h00382CBC, 1'b1, 16'h38BC, 16'h002C};
    vecs[5] = '{32'h02013E3F, 1'b0, 16'h0342, 16'h0000};
    vecs[6] = '{32'h4044003C, 1'b1, 16'h463C, 16'h0000};
    vecs[7] = '{32'hB83C3030, 1'b1, 16'h3834, 16'h0000};

    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    elem_i = '0; err_en_i = 1'b0; cur_exp = '0;
    #2;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    repeat (3) tick();
    rst_ni = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);

    // Single beats: latency and value per vector.
    for (int i = 0; i < 8; i++) begin
      drive(i);
      in_valid_i = 1'b1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready_o), 32'd1);
      tick();
      in_valid_i = 1'b0;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!out_valid_o && lat < 10);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_sum", i), 32'(sum_o), 32'(vecs[i].s));
      check($sformatf("vec%0d_error", i), 32'(error_o), 32'(vecs[i].e));
      tick();
      check($sformatf("vec%0d_popped", i), 32'(out_valid_o), 32'd0);
    end

    // Backpressure: credit admits exactly FIFO_DEPTH beats.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive(k % 8);
      rdy = in_ready_o;
      tick();
      if (rdy) k++;
    end
    in_valid_i = 1'b0;
    check("bp_accepted", 32'(k), 32'd4);
    check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
    p0 = pop_cnt;
    out_ready_i = 1'b1;
    for (int c = 0; c < 20 && pop_cnt - p0 < 4; c++) tick();
    tick();
    check("bp_drained", 32'(pop_cnt - p0), 32'd4);
    check("bp_in_ready_back", 32'(in_ready_o), 32'd1);
    check("bp_busy_idle", 32'(busy_o), 32'd0);

    // Back-to-back 8 beats with toggling consumer.
    p0 = pop_cnt;
    k = 0;
    in_valid_i = 1'b1;
    for (int c = 0; c < 60 && k < 8; c++) begin
      drive(k);
      rdy = in_ready_o;
      tick();
      out_ready_i = ~out_ready_i;
      if (rdy) k++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 30 && busy_o; c++) tick();
    check("b2b_all_out", 32'(pop_cnt - p0), 32'd8);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with 2 buffered and 2 in flight.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(0); tick();
    drive(1); tick();
    in_valid_i = 1'b0;
    repeat (3) tick();
    in_valid_i = 1'b1;
    drive(2); tick();
    drive(3); tick();
    drive(4);
    flush_i = 1'b1;
    check("flush_blocks_accept", 32'(in_ready_o), 32'd0);
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_out_valid", 32'(out_valid_o), 32'd0);
    check("flush_busy", 32'(busy_o), 32'd0);
    p0 = pop_cnt;
    out_ready_i = 1'b1;
    repeat (8) tick();
    check("flush_no_leak", 32'(pop_cnt - p0), 32'd0);

    // Asynchronous reset mid-stream.
    in_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(c);
      tick();
    end
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_sum", 32'(sum_o), 32'd0);
    check("arst_error", 32'(error_o), 32'd0);
    in_valid_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready_o), 32'd1);
    drive(6);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid_o && lat < 10);
    check("arst_first_latency", 32'(lat), 32'd3);
    check("arst_first_sum", 32'(sum_o), 32'(vecs[6].s));
    check("arst_first_error", 32'(error_o), 32'(vecs[6].e));
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
